ifu_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller that sequences the instruction ROM (word ROM, byte PC, base 0x3000).

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_range_chk.sv | 21 ++
 rtl/ifu_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared definitions for the instruction-fetch unit
//  Contents: FSM state encodings, default address-map parameters, instruction size.
package ifu_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 4096;

  localparam logic [31:0] INSTR_BYTES  = 32'd4;

endpackage

// File: rtl/ifu_range_chk.sv
// rtl/ifu_range_chk.sv - combinational fetch-address fault predicate
//  Used only when IFU_RANGE_CHECK_EN is defined.
//  Ports:
//   pc     in   32  byte address about to be fetched
//   fault  out  1   pc misaligned or outside [IM_BASE, IM_BASE + 4*IM_WORDS)
module ifu_range_chk
  import ifu_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int          IM_WORDS = DEF_IM_WORDS
) (
  input  logic [31:0] pc,
  output logic        fault
);

  // 33-bit limit so a ROM ending exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'(INSTR_BYTES);

  assign fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch controller between ROM and IF/ID
//  Optional feature macro: IFU_RANGE_CHECK_EN (fetch address range/alignment faults).
//  Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   im_pc / im_rd         ROM address (= pc_q) and combinational read data
//   if_valid/if_ready     fetch output handshake toward decode
//   if_instr/if_pc        registered instruction and its byte address
//   redirect_valid/target branch/jump redirect pulse and new PC
//   halt_req / halted     stop fetching after drain / in HALT state
//   if_fault              fetch fault flag (0 unless IFU_RANGE_CHECK_EN)
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int          IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] im_pc,
  input  logic [31:0] im_rd,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        if_fault
);

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic        adv;
  logic        fetch_fault;

  // Output stage may take a new word when empty or being consumed this cycle.
  assign adv = !if_valid || if_ready;

`ifdef IFU_RANGE_CHECK_EN
  ifu_range_chk #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_range_chk (
    .pc    (pc_q),
    .fault (fetch_fault)
  );
`else
  // No checking: the ROM simply wraps its index modulo IM_WORDS.
  logic unused_cfg;
  assign unused_cfg  = ^{IM_BASE, IM_WORDS};
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      state_q  <= ST_RUN;
      if_fault <= 1'b0;
    end else if (redirect_valid) begin
      // Flush the output stage; the target is fetched on the next cycle.
      pc_q     <= redirect_target;
      if_valid <= 1'b0;
      state_q  <= ST_RUN;
      if_fault <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            // Stop capturing; let any held word drain, then park.
            if (!if_valid) begin
              state_q <= ST_HALT;
            end else if (if_ready) begin
              if_valid <= 1'b0;
            end
          end else if (adv && fetch_fault) begin
            if_fault <= 1'b1;
            state_q  <= ST_FAULT;
            if (if_valid && if_ready) begin
              if_valid <= 1'b0;
            end
          end else if (adv) begin
            if_instr <= im_rd;
            if_pc    <= pc_q;
            if_valid <= 1'b1;
            pc_q     <= pc_q + INSTR_BYTES;
          end
        end
        default: begin
          // HALT / FAULT: no fetching, pc frozen, only drain a held word.
          if (if_valid && if_ready) begin
            if_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign im_pc  = pc_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] im_pc;
  logic [31:0] im_rd;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        halted;
  logic        if_fault;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rom [4096];
  logic [31:0] rom_off;

  always #5 clk = ~clk;

  // ROM model: word ROM at byte base 0x3000, low two bits ignored, index wraps.
  always_comb begin
    rom_off = im_pc - 32'h0000_3000;
    im_rd   = rom[rom_off[13:2]];
  end

  ifu_fetch_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .im_pc           (im_pc),
    .im_rd           (im_rd),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .halted          (halted),
    .if_fault        (if_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    if_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt_req        = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({if_valid, if_instr, if_pc, halted, if_fault, im_pc} !==
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3000}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b instr=%h pc=%h h=%b f=%b im_pc=%h, want v=0 instr=0 pc=0 h=0 f=0 im_pc=3000",
               if_valid, if_instr, if_pc, halted, if_fault, im_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * i);
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc, rom[i]}) begin
        miscompares++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                 i, if_valid, if_pc, if_instr, exp_pc, rom[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3004, rom[1]}) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h, want v=1 pc=3004 instr=%h",
                 i, if_valid, if_pc, if_instr, rom[1]);
      end
    end
    if_ready = 1'b1;
    step();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3008, rom[2]}) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h, want v=1 pc=3008 instr=%h",
               if_valid, if_pc, if_instr, rom[2]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    if_ready = 1'b0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h3100;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({if_valid, im_pc} !== {1'b0, 32'h3100}) begin
      miscompares++;
      $display("FAIL redirect_flush: got v=%b im_pc=%h, want v=0 im_pc=3100", if_valid, im_pc);
    end
    step();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3100, rom[12'h040]}) begin
      miscompares++;
      $display("FAIL redirect_fetch: got v=%b pc=%h instr=%h, want v=1 pc=3100 instr=%h",
               if_valid, if_pc, if_instr, rom[12'h040]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    step();
    step();
    step();
    halt_req = 1'b1;
    step();
    vectors++;
    if ({if_valid, halted} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_drain: got v=%b halted=%b, want v=0 halted=0", if_valid, halted);
    end
    step();
    halt_req = 1'b0;
    vectors++;
    if ({if_valid, halted} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL halt_enter: got v=%b halted=%b, want v=0 halted=1", if_valid, halted);
    end
    step();
    step();
    vectors++;
    if ({if_valid, halted, im_pc} !== {1'b0, 1'b1, 32'h300c}) begin
      miscompares++;
      $display("FAIL halt_frozen: got v=%b halted=%b im_pc=%h, want v=0 halted=1 im_pc=300c",
               if_valid, halted, im_pc);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h3000;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({if_valid, halted} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_exit: got v=%b halted=%b, want v=0 halted=0", if_valid, halted);
    end
    step();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3000, rom[0]}) begin
      miscompares++;
      $display("FAIL halt_resume: got v=%b pc=%h instr=%h, want v=1 pc=3000 instr=%h",
               if_valid, if_pc, if_instr, rom[0]);
    end
  endtask

  task automatic test_halt_and_redirect();
    do_reset();
    step();
    halt_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h3010;
    step();
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    vectors++;
    if ({if_valid, halted} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_redir_flush: got v=%b halted=%b, want v=0 halted=0", if_valid, halted);
    end
    step();
    vectors++;
    if ({if_valid, halted, if_pc, if_instr} !== {1'b1, 1'b0, 32'h3010, rom[4]}) begin
      miscompares++;
      $display("FAIL halt_redir_fetch: got v=%b h=%b pc=%h instr=%h, want v=1 h=0 pc=3010 instr=%h",
               if_valid, halted, if_pc, if_instr, rom[4]);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h3002;
    step();
    redirect_valid = 1'b0;
    step();
`ifdef IFU_RANGE_CHECK_EN
    vectors++;
    if ({if_valid, if_fault, im_pc} !== {1'b0, 1'b1, 32'h3002}) begin
      miscompares++;
      $display("FAIL fault_set: got v=%b fault=%b im_pc=%h, want v=0 fault=1 im_pc=3002",
               if_valid, if_fault, im_pc);
    end
    step();
    vectors++;
    if ({if_valid, if_fault} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL fault_hold: got v=%b fault=%b, want v=0 fault=1", if_valid, if_fault);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h3000;
    step();
    redirect_valid = 1'b0;
    vectors++;
    if ({if_valid, if_fault} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fault_clear: got v=%b fault=%b, want v=0 fault=0", if_valid, if_fault);
    end
    step();
    vectors++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h3000, rom[0]}) begin
      miscompares++;
      $display("FAIL fault_resume: got v=%b pc=%h instr=%h, want v=1 pc=3000 instr=%h",
               if_valid, if_pc, if_instr, rom[0]);
    end
`else
    vectors++;
    if ({if_valid, if_fault, if_pc, if_instr} !== {1'b1, 1'b0, 32'h3002, rom[0]}) begin
      miscompares++;
      $display("FAIL unaligned_wrap: got v=%b f=%b pc=%h instr=%h, want v=1 f=0 pc=3002 instr=%h",
               if_valid, if_fault, if_pc, if_instr, rom[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    step();
    if_ready = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    vectors++;
    if ({if_valid, if_instr, if_pc, halted, if_fault, im_pc} !==
        {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3000}) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got v=%b instr=%h pc=%h h=%b f=%b im_pc=%h, want v=0 instr=0 pc=0 h=0 f=0 im_pc=3000",
               if_valid, if_instr, if_pc, halted, if_fault, im_pc);
    end
    reset_n  = 1'b1;
    if_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    end
    reset_n         = 1'b0;
    if_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt_req        = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_halt_and_redirect();
    test_misaligned();
    test_reset_mid_stall();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
